// File: rtl/mips_timer.sv
// Memory-mapped countdown timer (CTRL/PRESET/COUNT/PRESCALE) driving the core's irq input.
// Optional prescaler: define MIPS_TIMER_PRESCALE_EN to enable the PRESCALE register at offset 3.
module mips_timer #(
   parameter logic [31:0] BASE = 32'h0000_7F00
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] addr,
   input  logic [3:0]  byteen,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        irq
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_LOAD = 2'd1;
   localparam logic [1:0] S_CNT  = 2'd2;
   localparam logic [1:0] S_INT  = 2'd3;

   localparam logic [1:0] OFF_CTRL   = 2'd0;
   localparam logic [1:0] OFF_PRESET = 2'd1;
   localparam logic [1:0] OFF_COUNT  = 2'd2;
   localparam logic [1:0] OFF_PSCL   = 2'd3;

   logic        r_en;
   logic [1:0]  r_mode;
   logic        r_im;
   logic [31:0] r_preset;
   logic [31:0] r_count;
   logic        r_flag;
   logic [1:0]  r_state;

   logic        w_sel;
   logic        w_wr;
   logic [1:0]  w_off;
   logic        w_wr_ctrl;
   logic        w_wr_preset;
   logic        w_auto;
   logic        w_tick;
   logic [31:0] w_pscl_rd;

   function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  be);
      logic [31:0] res;
      res = old_v;
      for (int i = 0; i < 4; i++)
         if (be[i]) res[8*i +: 8] = new_v[8*i +: 8];
      return res;
   endfunction

   assign w_sel       = ((addr & ~32'hF) == BASE);
   assign w_off       = addr[3:2];
   assign w_wr        = w_sel && (|byteen);
   assign w_wr_ctrl   = w_wr && (w_off == OFF_CTRL);
   assign w_wr_preset = w_wr && (w_off == OFF_PRESET);
   assign w_auto      = (r_mode == 2'b01);
   assign irq         = r_im & r_flag;

`ifdef MIPS_TIMER_PRESCALE_EN
   logic [15:0] r_prescale;
   logic [15:0] r_pcnt;
   logic        w_wr_pscl;
   logic [31:0] w_pscl_new;

   assign w_wr_pscl  = w_wr && (w_off == OFF_PSCL);
   assign w_pscl_new = merge_bytes({16'h0, r_prescale}, wdata, byteen);
   assign w_tick     = (r_pcnt == r_prescale);
   assign w_pscl_rd  = {16'h0, r_prescale};

   // Prescale counter only runs while CNT is actually decrementing a nonzero COUNT.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_prescale <= 16'h0;
         r_pcnt     <= 16'h0;
      end else begin
         if (w_wr_pscl) r_prescale <= w_pscl_new[15:0];
         if (r_state == S_IDLE || r_state == S_LOAD)
            r_pcnt <= 16'h0;
         else if (r_state == S_CNT && r_en && r_count != 32'h0)
            r_pcnt <= w_tick ? 16'h0 : r_pcnt + 16'h1;
      end
   end
`else
   assign w_tick    = 1'b1;
   assign w_pscl_rd = 32'h0;
`endif

   // Statement order matters: write-clear of the flag precedes the FSM set,
   // and the CTRL bus write follows the FSM's EN clear, so set and bus win respectively.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_en     <= 1'b0;
         r_mode   <= 2'b00;
         r_im     <= 1'b0;
         r_preset <= 32'h0;
         r_count  <= 32'h0;
         r_flag   <= 1'b0;
         r_state  <= S_IDLE;
      end else begin
         if (w_wr_ctrl || w_wr_preset) r_flag <= 1'b0;
         case (r_state)
            S_IDLE: if (r_en) r_state <= S_LOAD;
            S_LOAD: begin
               r_count <= r_preset;
               r_state <= S_CNT;
            end
            S_CNT: begin
               if (!r_en) begin
                  r_state <= S_IDLE;
               end else if (r_count == 32'h0) begin
                  r_state <= S_INT;
                  r_flag  <= 1'b1;
               end else if (w_tick) begin
                  r_count <= r_count - 32'h1;
               end
            end
            default: begin
               if (w_auto) begin
                  r_state <= S_LOAD;
                  r_flag  <= 1'b0;
               end else begin
                  r_state <= S_IDLE;
                  r_en    <= 1'b0;
               end
            end
         endcase
         if (w_wr_ctrl && byteen[0]) begin
            r_en   <= wdata[0];
            r_mode <= wdata[2:1];
            r_im   <= wdata[3];
         end
         if (w_wr_preset) r_preset <= merge_bytes(r_preset, wdata, byteen);
      end
   end

   always_comb begin
      rdata = 32'h0;
      if (w_sel) begin
         case (w_off)
            OFF_CTRL:   rdata = {28'h0, r_im, r_mode, r_en};
            OFF_PRESET: rdata = r_preset;
            OFF_COUNT:  rdata = r_count;
            default:    rdata = w_pscl_rd;
         endcase
      end
   end

endmodule

// File: tb/tb_mips_timer.sv
// Directed bench for mips_timer: register-access vector table plus hand-timed FSM sequences.
module tb_mips_timer;

   localparam logic [31:0] BASE   = 32'h0000_7F00;
   localparam logic [31:0] A_CTRL = BASE;
   localparam logic [31:0] A_PRE  = BASE + 32'h4;
   localparam logic [31:0] A_CNT  = BASE + 32'h8;
   localparam logic [31:0] A_PS   = BASE + 32'hC;
`ifdef MIPS_TIMER_PRESCALE_EN
   localparam logic [31:0] PS_EXP = 32'h0000_1234;
`else
   localparam logic [31:0] PS_EXP = 32'h0;
`endif

   typedef struct {
      logic [31:0] waddr;
      logic [3:0]  be;
      logic [31:0] wdata;
      logic [31:0] raddr;
      logic [31:0] exp;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] addr;
   logic [3:0]  byteen;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        irq;

   int n_chk = 0;
   int n_err = 0;

   mips_timer #(.BASE(BASE)) dut (
      .clk(clk), .reset(reset), .addr(addr), .byteen(byteen),
      .wdata(wdata), .rdata(rdata), .irq(irq)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not finish, got timeout required completion");
      $fatal(1, "timeout");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
      addr = a; byteen = be; wdata = d;
      @(posedge clk);
      #1;
      byteen = 4'h0;
   endtask

   task automatic rd(input logic [31:0] a, output logic [31:0] d);
      addr = a;
      #1;
      d = rdata;
   endtask

   task automatic chk_reg(input string name, input logic [31:0] a, input logic [31:0] exp);
      logic [31:0] v;
      rd(a, v);
      chk(name, v, exp);
   endtask

   task automatic chk_irq(input string name, input logic exp);
      chk(name, {31'h0, irq}, {31'h0, exp});
   endtask

   vec_t vecs[14];

   initial begin
      vecs[0]  = '{A_PRE,  4'hF, 32'hFFFF_FFFF, A_PRE,  32'hFFFF_FFFF};
      vecs[1]  = '{A_PRE,  4'h1, 32'h1234_5678, A_PRE,  32'hFFFF_FF78};
      vecs[2]  = '{A_PRE,  4'hC, 32'h1234_5678, A_PRE,  32'h1234_FF78};
      vecs[3]  = '{A_CTRL, 4'hF, 32'hFFFF_FFF6, A_CTRL, 32'h0000_0006};
      vecs[4]  = '{A_CTRL, 4'hE, 32'h0000_000F, A_CTRL, 32'h0000_0006};
      vecs[5]  = '{A_CNT,  4'hF, 32'h0000_DEAD, A_CNT,  32'h0};
      vecs[6]  = '{A_PS,   4'hF, 32'hABCD_1234, A_PS,   PS_EXP};
      vecs[7]  = '{BASE + 32'h10, 4'hF, 32'h0, A_PRE, 32'h1234_FF78};
      vecs[8]  = '{A_PRE,  4'h0, 32'h5555_5555, BASE + 32'h10, 32'h0};
      vecs[9]  = '{BASE - 32'h4,  4'hF, 32'h0, A_PRE, 32'h1234_FF78};
      vecs[10] = '{A_CTRL, 4'hF, 32'h0, A_CTRL, 32'h0};
      vecs[11] = '{A_PRE,  4'hF, 32'h0, A_PRE,  32'h0};
      vecs[12] = '{A_PRE,  4'h2, 32'hAABB_CCDD, A_PRE, 32'h0000_CC00};
      vecs[13] = '{A_PS,   4'hF, 32'h0, A_PS, 32'h0};

      reset = 1'b0; addr = 32'h0; byteen = 4'h0; wdata = 32'h0;
      tick(2);
      chk_reg("rst_ctrl", A_CTRL, 32'h0);
      chk_reg("rst_preset", A_PRE, 32'h0);
      chk_reg("rst_count", A_CNT, 32'h0);
      chk_irq("rst_irq", 1'b0);
      reset = 1'b1;

      foreach (vecs[i]) begin
         wr(vecs[i].waddr, vecs[i].be, vecs[i].wdata);
         chk_reg($sformatf("vec%0d", i), vecs[i].raddr, vecs[i].exp);
         chk_irq($sformatf("vec%0d_irq", i), 1'b0);
      end

      // one-shot, PRESET=5: irq at E+8, held until a CTRL write
      wr(A_PRE, 4'hF, 32'd5);
      wr(A_CTRL, 4'hF, 32'h9);
      tick(2);
      chk_reg("os_count_load", A_CNT, 32'd5);
      chk_irq("os_irq_e2", 1'b0);
      tick(5);
      chk_reg("os_count_zero", A_CNT, 32'd0);
      chk_irq("os_irq_e7", 1'b0);
      tick(1);
      chk_irq("os_irq_e8", 1'b1);
      tick(1);
      chk_reg("os_en_cleared", A_CTRL, 32'h8);
      tick(3);
      chk_irq("os_irq_held", 1'b1);
      wr(A_CTRL, 4'hF, 32'h8);
      chk_irq("os_irq_cleared", 1'b0);

      // IM=0 masks irq, expiry still ends one-shot
      wr(A_PRE, 4'hF, 32'd0);
      wr(A_CTRL, 4'hF, 32'h1);
      tick(5);
      chk_irq("mask_irq", 1'b0);
      chk_reg("mask_ctrl", A_CTRL, 32'h0);

      // flag set by FSM on the same edge as a CTRL write that sets IM: set wins
      wr(A_CTRL, 4'hF, 32'h1);
      tick(2);
      wr(A_CTRL, 4'hF, 32'h9);
      chk_irq("setwins_irq", 1'b1);
      tick(1);
      chk_irq("setwins_irq_hold", 1'b1);
      chk_reg("setwins_ctrl", A_CTRL, 32'h8);
      wr(A_CTRL, 4'hF, 32'h0);
      chk_irq("setwins_clear", 1'b0);

      // CTRL write on the edge where INT clears EN: bus value kept
      wr(A_CTRL, 4'hF, 32'h9);
      tick(3);
      chk_irq("buswins_e3", 1'b1);
      wr(A_CTRL, 4'hF, 32'h9);
      chk_irq("buswins_e4", 1'b0);
      chk_reg("buswins_ctrl", A_CTRL, 32'h9);
      tick(2);
      chk_irq("buswins_e6", 1'b0);
      tick(1);
      chk_irq("buswins_e7", 1'b1);
      wr(A_CTRL, 4'hF, 32'h0);
      tick(2);
      chk_irq("buswins_off", 1'b0);

      // auto-reload, PRESET=3: 1-cycle pulses every 6 cycles
      wr(A_PRE, 4'hF, 32'd3);
      wr(A_CTRL, 4'hF, 32'hB);
      for (int k = 1; k <= 20; k++) begin
         logic [31:0] exp_cnt;
         tick(1);
         chk_irq($sformatf("ar_irq_k%0d", k), (k >= 6) && (k % 6 == 0));
         if (k >= 2) begin
            case ((k - 2) % 6)
               0: exp_cnt = 32'd3;
               1: exp_cnt = 32'd2;
               2: exp_cnt = 32'd1;
               default: exp_cnt = 32'd0;
            endcase
            chk_reg($sformatf("ar_cnt_k%0d", k), A_CNT, exp_cnt);
         end
      end
      wr(A_CTRL, 4'hF, 32'h0);
      tick(4);
      chk_irq("ar_stopped", 1'b0);

      // stop mid-count, PRESET rewrite mid-count, then reset mid-count
      wr(A_PRE, 4'hF, 32'd10);
      wr(A_CTRL, 4'hF, 32'h9);
      tick(4);
      chk_reg("stop_cnt_e4", A_CNT, 32'd8);
      wr(A_PRE, 4'hF, 32'd2);
      chk_reg("stop_cnt_e5", A_CNT, 32'd7);
      wr(A_CTRL, 4'hF, 32'h0);
      tick(1);
      chk_reg("stop_cnt_frozen", A_CNT, 32'd6);
      tick(5);
      chk_reg("stop_cnt_still", A_CNT, 32'd6);
      chk_irq("stop_irq", 1'b0);
      wr(A_CTRL, 4'hF, 32'h9);
      tick(2);
      chk_reg("newpreset_cnt", A_CNT, 32'd2);
      reset = 1'b0;
      tick(1);
      reset = 1'b1;
      chk_reg("midrst_ctrl", A_CTRL, 32'h0);
      chk_reg("midrst_preset", A_PRE, 32'h0);
      chk_reg("midrst_count", A_CNT, 32'h0);
      chk_irq("midrst_irq", 1'b0);
      tick(4);
      chk_irq("midrst_irq_later", 1'b0);

      // prescale: PRESCALE=1, PRESET=2
      wr(A_PS, 4'hF, 32'd1);
      wr(A_PRE, 4'hF, 32'd2);
`ifdef MIPS_TIMER_PRESCALE_EN
      chk_reg("ps_read", A_PS, 32'd1);
      wr(A_CTRL, 4'hF, 32'h9);
      tick(6);
      chk_irq("ps_irq_e6", 1'b0);
      tick(1);
      chk_irq("ps_irq_e7", 1'b1);
`else
      chk_reg("ps_read", A_PS, 32'd0);
      wr(A_CTRL, 4'hF, 32'h9);
      tick(4);
      chk_irq("ps_irq_e4", 1'b0);
      tick(1);
      chk_irq("ps_irq_e5", 1'b1);
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
